// File: rtl/btn_pulse_conditioner.sv
// Push-button front end: synchronise, debounce, press-edge detect, auto-repeat on U,
// and a fixed-priority arbiter that issues at most one single-cycle pulse per clock.
module btn_pulse_conditioner #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int DEB_W      = 20,
    parameter bit REP_EN     = 1'b1,
    parameter int REP_DELAY  = 25_000_000,
    parameter int REP_RATE   = 10_000_000,
    parameter int REP_W      = 25
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       btn_enter,
    input  logic       btn_u,
    input  logic       btn_lu,
    output logic       Enter,
    output logic       U,
    output logic       LU,
    output logic [2:0] btn_level
);

    localparam logic [DEB_W-1:0] DEB_LAST       = DEB_W'(DEB_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_FIRST_LAST = REP_W'(REP_DELAY - 1);
    localparam logic [REP_W-1:0] REP_NEXT_LAST  = REP_W'(REP_RATE - 1);

    // Bit order everywhere is {lu, u, enter}.
    logic [2:0]       raw;
    logic [2:0]       s1;
    logic [2:0]       s2;
    logic [DEB_W-1:0] cnt [3];
    logic [2:0]       press;
    logic [2:0]       events;
    logic [2:0]       pending;
    logic [2:0]       grant;
    logic [REP_W-1:0] rcnt;
    logic [REP_W-1:0] rep_limit;
    logic             rep_first_done;
    logic             rep_fire;

    assign raw = {btn_lu, btn_u, btn_enter};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            btn_level <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_LAST) begin
                    btn_level[i] <= s2[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // A press is the edge on which the debounced level is about to go 0->1.
    always_comb begin
        press = '0;
        for (int i = 0; i < 3; i++) begin
            press[i] = s2[i] && !btn_level[i] && (cnt[i] == DEB_LAST);
        end
    end

    assign rep_limit = rep_first_done ? REP_NEXT_LAST : REP_FIRST_LAST;
    assign rep_fire  = REP_EN && btn_level[1] && (rcnt == rep_limit);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rcnt           <= '0;
            rep_first_done <= 1'b0;
        end else if (!REP_EN || press[1] || !btn_level[1]) begin
            rcnt           <= '0;
            rep_first_done <= 1'b0;
        end else if (rcnt == rep_limit) begin
            rcnt           <= '0;
            rep_first_done <= 1'b1;
        end else begin
            rcnt <= rcnt + REP_W'(1);
        end
    end

    assign events = press | {1'b0, rep_fire, 1'b0};

    // Enter > LU > U; a same-edge event re-sets the bit being granted.
    always_comb begin
        grant = 3'b000;
        if (pending[0])      grant = 3'b001;
        else if (pending[2]) grant = 3'b100;
        else if (pending[1]) grant = 3'b010;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pending <= '0;
            Enter   <= 1'b0;
            U       <= 1'b0;
            LU      <= 1'b0;
        end else begin
            pending <= (pending & ~grant) | events;
            Enter   <= grant[0];
            U       <= grant[1];
            LU      <= grant[2];
        end
    end

endmodule
